// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - MIPS decode/issue stage feeding the ALU through a 2-entry skid buffer
// Optional ALU_ISSUE_TRAP_EN adds a sticky trap output raised when an illegal entry is dequeued.
module alu_issue #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [31:0]      in_rs,
  input  logic [31:0]      in_rt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_A,
  output logic [31:0]      out_B,
  output logic [3:0]       out_ALUop,
  output logic [TAG_W-1:0] out_dest,
  output logic [1:0]       out_branch,
  output logic             out_illegal
`ifdef ALU_ISSUE_TRAP_EN
  ,
  output logic             trap
`endif
);

  localparam logic [3:0] OP_ADDU = 4'd0;
  localparam logic [3:0] OP_SUBU = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_LUI  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_XXX  = 4'd15;

  // Entry layout, LSB first: A, B, ALUop, dest, branch, illegal.
  localparam int EW = 71 + TAG_W;
  localparam logic [EW-1:0] LP_RST = {1'b0, 2'b00, {TAG_W{1'b0}}, OP_XXX, 64'd0};
  localparam logic [1:0] LP_DEPTH = DEPTH[1:0];

  logic [5:0]       w_opc;
  logic [5:0]       w_funct;
  logic [TAG_W-1:0] w_rd;
  logic [TAG_W-1:0] w_rt;
  logic [31:0]      w_shamt;
  logic [31:0]      w_rs5;
  logic [31:0]      w_simm;
  logic [31:0]      w_zimm;

  assign w_opc   = in_insn[31:26];
  assign w_funct = in_insn[5:0];
  assign w_rd    = TAG_W'(in_insn[15:11]);
  assign w_rt    = TAG_W'(in_insn[20:16]);
  assign w_shamt = {27'd0, in_insn[10:6]};
  assign w_rs5   = {27'd0, in_rs[4:0]};
  assign w_simm  = {{16{in_insn[15]}}, in_insn[15:0]};
  assign w_zimm  = {16'd0, in_insn[15:0]};

  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [3:0]       w_op;
  logic [TAG_W-1:0] w_dest;
  logic [1:0]       w_br;
  logic             w_ill;

  // Operand order follows the ALU: SLL/SRL compute A op B, SRA computes B >>> A.
  always_comb begin
    w_a = '0; w_b = '0; w_op = OP_XXX; w_dest = '0; w_br = 2'b00; w_ill = 1'b1;
    case (w_opc)
      6'h00: begin
        w_a = in_rs; w_b = in_rt; w_dest = w_rd; w_ill = 1'b0;
        case (w_funct)
          6'h21: w_op = OP_ADDU;
          6'h23: w_op = OP_SUBU;
          6'h24: w_op = OP_AND;
          6'h25: w_op = OP_OR;
          6'h26: w_op = OP_XOR;
          6'h27: w_op = OP_NOR;
          6'h2A: w_op = OP_SLT;
          6'h2B: w_op = OP_SLTU;
          6'h00: begin w_op = OP_SLL; w_a = in_rt;   w_b = w_shamt; end
          6'h02: begin w_op = OP_SRL; w_a = in_rt;   w_b = w_shamt; end
          6'h03: begin w_op = OP_SRA; w_a = w_shamt; w_b = in_rt;   end
          6'h04: begin w_op = OP_SLL; w_a = in_rt;   w_b = w_rs5;   end
          6'h06: begin w_op = OP_SRL; w_a = in_rt;   w_b = w_rs5;   end
          6'h07: begin w_op = OP_SRA; w_a = w_rs5;   w_b = in_rt;   end
          default: begin w_a = '0; w_b = '0; w_dest = '0; w_ill = 1'b1; end
        endcase
      end
      6'h09: begin w_op = OP_ADDU; w_a = in_rs; w_b = w_simm; w_dest = w_rt; w_ill = 1'b0; end
      6'h0A: begin w_op = OP_SLT;  w_a = in_rs; w_b = w_simm; w_dest = w_rt; w_ill = 1'b0; end
      6'h0B: begin w_op = OP_SLTU; w_a = in_rs; w_b = w_simm; w_dest = w_rt; w_ill = 1'b0; end
      6'h0C: begin w_op = OP_AND;  w_a = in_rs; w_b = w_zimm; w_dest = w_rt; w_ill = 1'b0; end
      6'h0D: begin w_op = OP_OR;   w_a = in_rs; w_b = w_zimm; w_dest = w_rt; w_ill = 1'b0; end
      6'h0E: begin w_op = OP_XOR;  w_a = in_rs; w_b = w_zimm; w_dest = w_rt; w_ill = 1'b0; end
      6'h0F: begin w_op = OP_LUI;  w_a = w_zimm; w_b = '0;    w_dest = w_rt; w_ill = 1'b0; end
      6'h23: begin w_op = OP_ADDU; w_a = in_rs; w_b = w_simm; w_dest = w_rt; w_ill = 1'b0; end
      6'h2B: begin w_op = OP_ADDU; w_a = in_rs; w_b = w_simm; w_ill = 1'b0; end
      6'h04: begin w_op = OP_SUBU; w_a = in_rs; w_b = in_rt; w_br = 2'b01; w_ill = 1'b0; end
      6'h05: begin w_op = OP_SUBU; w_a = in_rs; w_b = in_rt; w_br = 2'b10; w_ill = 1'b0; end
      default: ;
    endcase
  end

  logic [EW-1:0] r_e0;
  logic [EW-1:0] r_e1;
  logic [1:0]    r_count;
  logic          r_in_ready;
  logic          w_enq;
  logic          w_deq;
  logic [1:0]    w_count_nxt;
  logic          w_trap_nxt;
  logic [EW-1:0] w_entry;

  assign w_entry     = {w_ill, w_br, w_dest, w_op, w_b, w_a};
  assign w_enq       = in_valid & r_in_ready;
  assign w_deq       = (r_count != 2'd0) & out_ready;
  assign w_count_nxt = r_count + {1'b0, w_enq} - {1'b0, w_deq};

`ifdef ALU_ISSUE_TRAP_EN
  logic r_trap;
  assign w_trap_nxt = r_trap | (w_deq & r_e0[EW-1]);
  assign trap       = r_trap;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) r_trap <= 1'b0;
    else                 r_trap <= w_trap_nxt;
  end
`else
  assign w_trap_nxt = 1'b0;
`endif

  // r_e0 is the head; it is left untouched on the last pop so outputs hold when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
      r_e0       <= LP_RST;
      r_e1       <= LP_RST;
    end else if (flush) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt < LP_DEPTH) && !w_trap_nxt;
      if (w_enq && (r_count == 2'd0 || (r_count == 2'd1 && w_deq))) r_e0 <= w_entry;
      else if (w_deq && r_count == 2'd2)                             r_e0 <= r_e1;
      if (w_enq && r_count == 2'd1 && !w_deq)                        r_e1 <= w_entry;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_count != 2'd0);
  assign out_A       = r_e0[31:0];
  assign out_B       = r_e0[63:32];
  assign out_ALUop   = r_e0[67:64];
  assign out_dest    = r_e0[68 +: TAG_W];
  assign out_branch  = r_e0[68 + TAG_W +: 2];
  assign out_illegal = r_e0[EW-1];

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a table-driven reference decoder
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_insn = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic [3:0]  out_ALUop;
  logic [4:0]  out_dest;
  logic [1:0]  out_branch;
  logic        out_illegal;
`ifdef ALU_ISSUE_TRAP_EN
  logic        trap;
`endif

  alu_issue #(.TAG_W(5), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_rs(in_rs), .in_rt(in_rt), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A), .out_B(out_B),
    .out_ALUop(out_ALUop), .out_dest(out_dest), .out_branch(out_branch),
    .out_illegal(out_illegal)
`ifdef ALU_ISSUE_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic [1:0]  br;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  bit   rand_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder: mnemonic-level rules, one line per instruction class.
  function automatic exp_t model(input logic [31:0] insn, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [31:0] sh, rsa, simm, zimm;
    sh   = 32'(insn[10:6]);
    rsa  = rs & 32'h1F;
    zimm = insn & 32'hFFFF;
    simm = insn[15] ? (zimm | 32'hFFFF0000) : zimm;
    e = '{a: 0, b: 0, op: 15, dest: 0, br: 0, ill: 1};
    if (insn[31:26] == 0) begin
      case (insn[5:0])
        'h21: e = '{rs, rt, 0, insn[15:11], 0, 0};
        'h23: e = '{rs, rt, 1, insn[15:11], 0, 0};
        'h24: e = '{rs, rt, 4, insn[15:11], 0, 0};
        'h25: e = '{rs, rt, 5, insn[15:11], 0, 0};
        'h26: e = '{rs, rt, 6, insn[15:11], 0, 0};
        'h27: e = '{rs, rt, 11, insn[15:11], 0, 0};
        'h2A: e = '{rs, rt, 2, insn[15:11], 0, 0};
        'h2B: e = '{rs, rt, 3, insn[15:11], 0, 0};
        'h00: e = '{rt, sh, 8, insn[15:11], 0, 0};
        'h02: e = '{rt, sh, 9, insn[15:11], 0, 0};
        'h03: e = '{sh, rt, 10, insn[15:11], 0, 0};
        'h04: e = '{rt, rsa, 8, insn[15:11], 0, 0};
        'h06: e = '{rt, rsa, 9, insn[15:11], 0, 0};
        'h07: e = '{rsa, rt, 10, insn[15:11], 0, 0};
        default: ;
      endcase
    end else begin
      case (insn[31:26])
        'h09: e = '{rs, simm, 0, insn[20:16], 0, 0};
        'h0A: e = '{rs, simm, 2, insn[20:16], 0, 0};
        'h0B: e = '{rs, simm, 3, insn[20:16], 0, 0};
        'h0C: e = '{rs, zimm, 4, insn[20:16], 0, 0};
        'h0D: e = '{rs, zimm, 5, insn[20:16], 0, 0};
        'h0E: e = '{rs, zimm, 6, insn[20:16], 0, 0};
        'h0F: e = '{zimm, 0, 7, insn[20:16], 0, 0};
        'h23: e = '{rs, simm, 0, insn[20:16], 0, 0};
        'h2B: e = '{rs, simm, 0, 0, 0, 0};
        'h04: e = '{rs, rt, 1, 0, 1, 0};
        'h05: e = '{rs, rt, 1, 0, 2, 0};
        default: ;
      endcase
    end
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  logic        prev_stall = 0;
  logic [31:0] prev_a, prev_b;
  logic [3:0]  prev_op;
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall && out_valid) begin
      chk("hold_A", out_A, prev_a);
      chk("hold_B", out_B, prev_b);
      chk("hold_op", {28'd0, out_ALUop}, {28'd0, prev_op});
    end
    prev_stall = rst_n && !flush && out_valid && !out_ready;
    prev_a = out_A; prev_b = out_B; prev_op = out_ALUop;
    if (!rst_n || flush) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      pops++;
      if (sb.size() == 0) begin
        chk("unexpected_pop", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_A", out_A, e.a);
        chk("sb_B", out_B, e.b);
        chk("sb_op", {28'd0, out_ALUop}, {28'd0, e.op});
        chk("sb_dest", {27'd0, out_dest}, {27'd0, e.dest});
        chk("sb_branch", {30'd0, out_branch}, {30'd0, e.br});
        chk("sb_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [31:0] insn, input logic [31:0] rs, input logic [31:0] rt);
    int n = 0;
    bit done = 0;
    in_insn = insn; in_rs = rs; in_rt = rt; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(insn, rs, rt));
        done = 1;
      end else if (++n > 200) begin
        chk("send_timeout", 32'd1, 32'd0);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] dest, input logic ill);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_op"}, {28'd0, out_ALUop}, {28'd0, op});
    chk({name, "_A"}, out_A, a);
    chk({name, "_B"}, out_B, b);
    chk({name, "_dest"}, {27'd0, out_dest}, {27'd0, dest});
    chk({name, "_ill"}, {31'd0, out_illegal}, {31'd0, ill});
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || in_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_op"}, {28'd0, out_ALUop}, 32'd15);
    chk({name, "_A"}, out_A, 32'd0);
    chk({name, "_B"}, out_B, 32'd0);
    chk({name, "_dest"}, {27'd0, out_dest}, 32'd0);
    chk({name, "_branch"}, {30'd0, out_branch}, 32'd0);
    chk({name, "_ill"}, {31'd0, out_illegal}, 32'd0);
  endtask

  logic [5:0] rfn[14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21,
                          6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [5:0] iop[11] = '{6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                          6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w = {6'h00, w[25:6], rfn[$urandom_range(0, 13)]};
      1: w = {iop[$urandom_range(0, 10)], w[25:0]};
      2: w = {6'h00, w[25:0]};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int p0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state("reset");

    @(posedge clk); #1;
    send(32'h00221821, 32'd5, 32'd7);
    check_head("addu", 4'd0, 32'd5, 32'd7, 5'd3, 1'b0);
    send(32'h00021903, 32'd0, 32'h80000000);
    check_head("sra", 4'd10, 32'd4, 32'h80000000, 5'd3, 1'b0);
    send(32'h00021900, 32'd0, 32'h80000000);
    check_head("sll", 4'd8, 32'h80000000, 32'd4, 5'd3, 1'b0);
    send(32'h2424FFFF, 32'd10, 32'd0);
    check_head("addiu", 4'd0, 32'd10, 32'hFFFFFFFF, 5'd4, 1'b0);
    send(32'h3424FFFF, 32'd10, 32'd0);
    check_head("ori", 4'd5, 32'd10, 32'h0000FFFF, 5'd4, 1'b0);
    send(32'h3C041234, 32'd10, 32'd0);
    check_head("lui", 4'd7, 32'h1234, 32'd0, 5'd4, 1'b0);

    // Backpressure: third insn must wait for space, order preserved.
    p0 = pops;
    send(32'h00221821, 32'd1, 32'd1);
    send(32'h00221821, 32'd2, 32'd2);
    @(negedge clk);
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_head_A", out_A, 32'd1);
    @(posedge clk); #1;
    fork
      send(32'h00221821, 32'd3, 32'd3);
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_held", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_pops", pops - p0, 3);
    out_ready = 1'b0;

    // Flush with an insn offered in the same cycle.
    send(32'h00221821, 32'd4, 32'd4);
    send(32'h00221821, 32'd5, 32'd5);
    in_insn = 32'h00221821; in_rs = 32'd9; in_rt = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("flush_dropped", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    send(32'hFC000000, 32'd1, 32'd2);
    check_head("illegal", 4'd15, 32'd0, 32'd0, 5'd0, 1'b1);

    // Mid-operation reset discards contents.
    send(32'h00221821, 32'd6, 32'd6);
    send(32'h00221821, 32'd7, 32'd7);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state("midreset");

    @(posedge clk); #1;
    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(rand_insn(), $urandom, $urandom);
    end
    rand_mode = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("final_drain");
    @(negedge clk);
    chk("final_out_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that produces the ALU's inputs: operands A and B and the 4-bit ALUop, plus the destination tag.
- Accepts one instruction word with its rs/rt register values per valid/ready handshake.
- Holds results in a 2-entry skid buffer and presents them to the execute stage with its own valid/ready handshake.
- Drives operands in the exact order the ALU expects per op.

Parameters:
- TAG_W, 5, width of destination register tag.
- DEPTH, 2, skid buffer entries (only 2 supported).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  stage can accept
- in_insn  in  32  MIPS instruction word
- in_rs  in  32  rs register value
- in_rt  in  32  rt register value
- flush  in  1  discard all buffered entries
- out_valid  out  1  entry available for execute
- out_ready  in  1  execute consumes entry
- out_A  out  32  ALU operand A
- out_B  out  32  ALU operand B
- out_ALUop  out  4  ALU operation
- out_dest  out  TAG_W  destination register (0 = no write)
- out_branch  out  2  00 none, 01 BEQ, 10 BNE
- out_illegal  out  1  undecodable instruction

Behaviour:
- Interface: clk rising edge; rst_n synchronous, active low.
- ALUop encodings:
  - ADDU 0, SUBU 1, SLT 2, SLTU 3, AND 4, OR 5, XOR 6, LUI 7
  - SLL 8, SRL 9, SRA 10, NOR 11, XXX 15
- R-type (opcode 0x00), dest = rd:
  - funct 0x21/0x23/0x24/0x25/0x26/0x27/0x2A/0x2B → ADDU/SUBU/AND/OR/XOR/NOR/SLT/SLTU; A=rs, B=rt.
- R-type shifts (ALU computes SLL/SRL as A op B, SRA as B>>>A):
  - SLL 0x00: A=rt, B=shamt zero-extended.
  - SRL 0x02: A=rt, B=shamt zero-extended.
  - SRA 0x03: A=shamt zero-extended, B=rt.
  - SLLV 0x04 / SRLV 0x06: B=rs[4:0] zero-extended.
  - SRAV 0x07: A=rs[4:0] zero-extended, B=rt.
- I-type, dest = rt:
  - ADDIU 0x09 / SLTI 0x0A / SLTIU 0x0B: A=rs, B=sign-extended imm.
  - ANDI 0x0C / ORI 0x0D / XORI 0x0E: A=rs, B=zero-extended imm.
  - LUI 0x0F: ALUop LUI, A=zero-extended imm, B=0.
  - LW 0x23: ADDU, A=rs, B=sign-extended imm.
  - SW 0x2B: ADDU, A=rs, B=sign-extended imm, dest=0.
  - BEQ 0x04 / BNE 0x05: SUBU, A=rs, B=rt, dest=0, out_branch set.
- Any other opcode/funct:
  - ALUop=XXX, A=B=0, dest=0, out_illegal=1.
  - Entry still enqueued.
- Buffer:
  - 2 entries; head drives out_* directly from registers.
  - Latency: accepted insn visible on out_* the next cycle.
  - in_ready = (count<2); registered, not combinationally dependent on out_ready.
  - Accept when in_valid&in_ready; dequeue when out_valid&out_ready.
  - Simultaneous enqueue and dequeue: count unchanged; order preserved FIFO.
  - Count 1 with dequeue only → 0. Count 2 → in_ready=0, no loss.
  - out_valid=(count!=0); out_* hold stable while out_valid&!out_ready.
- flush:
  - Next cycle count=0, out_valid=0, in_ready=1.
  - Any insn offered in the same cycle is dropped.
  - Flush has priority over enqueue and dequeue.
- Reset (rst_n=0 at edge):
  - count=0, in_ready=1, out_valid=0.
  - out_A=out_B=0, out_ALUop=15, out_dest=0, out_branch=0, out_illegal=0.
  - Mid-operation reset discards contents identically.
- Empty buffer: out_* hold last-popped values; only out_valid is meaningful.

Optional Feature:
- Macro: ALU_ISSUE_TRAP_EN.
- Defined:
  - Adds output trap (1 bit), a sticky flag set when an illegal entry is dequeued.
  - While trap=1, in_ready=0.
  - trap is cleared only by flush or reset.
- Undefined:
  - No trap port; illegal entries flow through with out_illegal=1 only.

Test Plan:
- Reset: hold rst_n=0 two cycles → out_valid=0, in_ready=1, out_ALUop=15, out_A=0.
- ADDU: issue 0x00221821 (addu $3,$1,$2), rs=5, rt=7, out_ready=1 → next cycle out_ALUop=0, A=5, B=7, dest=3.
- Shift ordering:
  - sra $3,$2,4 (0x00021903), rt=0x80000000 → ALUop=10, A=4, B=0x80000000.
  - sll $3,$2,4 (0x00021900) → ALUop=8, A=0x80000000, B=4.
- Immediates:
  - addiu $4,$1,-1 (0x2424FFFF), rs=10 → ALUop=0, B=0xFFFFFFFF, dest=4.
  - ori 0x3424FFFF → ALUop=5, B=0x0000FFFF.
  - lui 0x3C041234 → ALUop=7, A=0x1234.
- Backpressure: out_ready=0, push three insns back-to-back → in_ready drops after 2, third held by source. Release out_ready → entries appear in order, none lost or duplicated.
- Flush/illegal:
  - Two entries buffered, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, offered insn not enqueued.
  - Then issue 0xFC000000 → out_illegal=1, ALUop=15, dest=0.
